// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction-fetch stage.
// Owns the PC, drives the synchronous instruction memory and presents the
// PC/instruction pair to IF/ID. Honours hazard-unit stall and EX redirect.
// Optional feature macro: FETCH_SKID_EN (skid register captures the held
// instruction so HOLD does not depend on imem output-hold behaviour).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [XLEN-1:0] pc_q;
  logic            pc_we;
  logic            boot;
  logic [XLEN-1:0] hold_inst;

  assign boot = (state_q == BOOT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // pc_q tracks the address whose data is on imem_dout this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_we) begin
      pc_q <= imem_addr;
    end
  end

`ifdef FETCH_SKID_EN
  logic [XLEN-1:0] skid_q;
  logic            skid_we;

  // Capture the RUN-cycle instruction on the way into HOLD
  assign skid_we = (state_q == RUN) && stall && !redirect_valid;

  // Skid register for the held instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= NOP_INST;
    end else if (skid_we) begin
      skid_q <= imem_dout;
    end
  end

  assign hold_inst = skid_q;
`else
  // Relies on imem keeping its output while imem_en is low
  assign hold_inst = imem_dout;
`endif

  // Next-address selection and imem enable
  always_comb begin
    imem_addr = pc_q + PC_STEP;
    imem_en   = 1'b1;
    pc_we     = 1'b0;
    if (rst || boot) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr = redirect_pc & ALIGN_MASK;
    end else if (stall) begin
      imem_addr = pc_q;
      imem_en   = 1'b0;
    end
    pc_we = imem_en && !boot && !rst;
  end

  // Next-state and IF/ID output decode
  always_comb begin
    state_d     = state_q;
    if_id_pc    = pc_q;
    if_id_inst  = NOP_INST;
    if_id_valid = 1'b0;
    case (state_q)
      BOOT: begin
        if_id_pc = RESET_PC;
        state_d  = RUN;
      end
      RUN: begin
        if (!redirect_valid) begin
          if_id_inst  = imem_dout;
          if_id_valid = 1'b1;
          if (stall) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = RUN;
        end else begin
          if_id_inst  = hold_inst;
          if_id_valid = 1'b1;
          if (!stall) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        if_id_pc = RESET_PC;
        state_d  = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous imem model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  int n_cmp;
  int n_err;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_dout      (imem_dout),
    .if_id_pc       (if_id_pc),
    .if_id_inst     (if_id_inst),
    .if_id_valid    (if_id_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous imem; holds output when disabled unless skid build corrupts it
  always @(posedge clk) begin
    if (imem_en) begin
      imem_dout <= mem_fn(imem_addr);
    end else begin
`ifdef FETCH_SKID_EN
      imem_dout <= 32'hDEAD_BEEF;
`else
      imem_dout <= imem_dout;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc,
                         input logic [31:0] inst, input logic valid);
    chk({tag, ".pc"},    if_id_pc,             pc);
    chk({tag, ".inst"},  if_id_inst,           inst);
    chk({tag, ".valid"}, 32'(if_id_valid),     32'(valid));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Held in reset
    repeat (2) @(posedge clk);
    smp();
    chk_out("reset", RST_PC, NOP, 1'b0);
    chk("reset.en",   32'(imem_en), 32'd1);
    chk("reset.addr", imem_addr,    RST_PC);

    // Release: BOOT cycle, then sequential fetch
    cyc(); rst = 1'b0;
    smp();
    chk_out("boot", RST_PC, NOP, 1'b0);
    chk("boot.addr", imem_addr, RST_PC);

    cyc(); smp();
    chk_out("run0", 32'h4000_0000, mem_fn(32'h4000_0000), 1'b1);
    chk("run0.addr", imem_addr, 32'h4000_0004);

    cyc(); smp();
    chk_out("run1", 32'h4000_0004, mem_fn(32'h4000_0004), 1'b1);

    // Single-cycle stall at 4000_0008
    cyc(); stall = 1'b1; smp();
    chk_out("stall", 32'h4000_0008, mem_fn(32'h4000_0008), 1'b1);
    chk("stall.en", 32'(imem_en), 32'd0);

    cyc(); stall = 1'b0; smp();
    chk_out("hold", 32'h4000_0008, mem_fn(32'h4000_0008), 1'b1);
    chk("hold.en",   32'(imem_en), 32'd1);
    chk("hold.addr", imem_addr,    32'h4000_000C);

    cyc(); smp();
    chk_out("resume", 32'h4000_000C, mem_fn(32'h4000_000C), 1'b1);

    // Redirect at 4000_0010
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h4000_0100; smp();
    chk("redir.inst",  if_id_inst,           NOP);
    chk("redir.valid", 32'(if_id_valid),     32'd0);
    chk("redir.addr",  imem_addr,            32'h4000_0100);
    chk("redir.en",    32'(imem_en),         32'd1);

    cyc(); redirect_valid = 1'b0; smp();
    chk_out("target", 32'h4000_0100, mem_fn(32'h4000_0100), 1'b1);

    // Redirect and stall together: redirect wins, no HOLD
    cyc(); redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h4000_0100; smp();
    chk("rs.inst",  if_id_inst,       NOP);
    chk("rs.valid", 32'(if_id_valid), 32'd0);
    chk("rs.en",    32'(imem_en),     32'd1);
    chk("rs.addr",  imem_addr,        32'h4000_0100);

    cyc(); redirect_valid = 1'b0; stall = 1'b0; smp();
    chk_out("rs_target", 32'h4000_0100, mem_fn(32'h4000_0100), 1'b1);

    cyc(); smp();
    chk_out("rs_next", 32'h4000_0104, mem_fn(32'h4000_0104), 1'b1);

    // Misaligned redirect target has its low bits dropped
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h4000_0203; smp();
    chk("align.addr", imem_addr, 32'h4000_0200);

    cyc(); redirect_valid = 1'b0; smp();
    chk_out("align", 32'h4000_0200, mem_fn(32'h4000_0200), 1'b1);

    // Two-cycle stall at 4000_0204, then async reset mid-HOLD
    cyc(); stall = 1'b1; smp();
    chk_out("stall2", 32'h4000_0204, mem_fn(32'h4000_0204), 1'b1);
    chk("stall2.en", 32'(imem_en), 32'd0);

    cyc(); smp();
    chk_out("hold2", 32'h4000_0204, mem_fn(32'h4000_0204), 1'b1);
    chk("hold2.en", 32'(imem_en), 32'd0);

    #1; rst = 1'b1; stall = 1'b0;
    #1;
    chk_out("async_rst", RST_PC, NOP, 1'b0);
    chk("async_rst.en",   32'(imem_en), 32'd1);
    chk("async_rst.addr", imem_addr,    RST_PC);

    cyc(); rst = 1'b0; smp();
    chk_out("reboot", RST_PC, NOP, 1'b0);

    cyc(); smp();
    chk_out("rerun0", 32'h4000_0000, mem_fn(32'h4000_0000), 1'b1);

    cyc(); smp();
    chk_out("rerun1", 32'h4000_0004, mem_fn(32'h4000_0004), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V core: owns the PC, drives the synchronous instruction memory, and delivers the PC/instruction pair to the IF/ID boundary. It is the responder to the hazard-detection unit. It honours that unit's PC-stall and imem-enable semantics and the EX-stage redirect, replays stalled instructions, and squashes wrong-path fetches to NOP.

## Interface
- RESET_PC, default 32'h4000_0000: first instruction address after reset.
- NOP_INST, default 32'h0000_0013: addi x0,x0,0 used for bubbles.
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the current IF/ID instruction for one more cycle (inverse of the PC-enable from hazard detection).
- redirect_valid  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target address, word aligned.
- imem_addr  output  32  byte address presented to imem this cycle (imem uses [15:2]).
- imem_en  output  1  imem read enable; imem output holds when low.
- imem_dout  input  32  imem read data, valid one cycle after address/enable.
- if_id_pc  output  32  PC of if_id_inst.
- if_id_inst  output  32  instruction to ID.
- if_id_valid  output  1  1 = real instruction, 0 = bubble (inst is NOP_INST).

## Operation
- State register: BOOT, RUN, HOLD. pc_q (32 b) = address whose data is on imem_dout this cycle.
- Next-address priority (combinational): rst or BOOT -> RESET_PC; redirect_valid -> redirect_pc; stall -> pc_q; else pc_q + 4 (wraps mod 2^32).
- imem_en = rst | BOOT | redirect_valid | !stall. pc_q <= imem_addr whenever imem_en, except in BOOT (pc_q stays RESET_PC).
- BOOT: output NOP_INST, valid 0, if_id_pc = RESET_PC; -> RUN.
- RUN: if_id_inst = imem_dout, if_id_pc = pc_q, valid 1. stall & !redirect_valid -> HOLD. Else remain in RUN.
- HOLD: present the same pc/inst as the previous cycle, valid 1. !stall or redirect_valid -> RUN; stall again -> stay in HOLD (no one-cycle limit enforced here).
- Redirect (any state except BOOT): this cycle's output is squashed (NOP_INST, valid 0). Target instruction appears next cycle with if_id_pc = redirect_pc.
- redirect_valid and stall together: redirect wins; the stall is ignored.
- redirect_pc[1:0] must be 0. They are ignored (forced 0) on imem_addr.

## Timing
- Reset values (asynchronous): state BOOT, pc_q = RESET_PC, if_id_valid 0, if_id_inst NOP_INST, if_id_pc RESET_PC, imem_en 1, imem_addr RESET_PC.
- Fetch latency: address in cycle N -> instruction at IF/ID in N+1. First valid instruction arrives 2 cycles after rst deassert (BOOT, then RESET_PC).
- Redirect penalty: 1 bubble cycle in IF (the redirect cycle itself). The ID-register flush remains the hazard unit's job.
- Stall: output is identical in cycles N and N+1 when stall is high in N. A new fetch resumes the cycle stall drops.
- rst asserted mid-run: outputs go to reset values immediately. Any in-flight imem data is discarded.

## Configuration
- FETCH_SKID_EN defined: a 32-bit skid register captures if_id_inst on entry to HOLD. HOLD outputs come from the skid register, so correctness does not depend on the imem output-hold behaviour.
- FETCH_SKID_EN undefined: no skid register. HOLD outputs imem_dout directly, relying on imem holding its output while imem_en = 0. Outputs are cycle-identical to the defined case when imem holds correctly.

## Test plan
- Reset release, no stall/redirect -> cycle 0 valid 0 NOP, cycle 1 pc 4000_0000, cycle 2 pc 4000_0004, cycle 3 pc 4000_0008, inst = memory contents.
- stall high 1 cycle at pc 4000_0008 -> that pc/inst is output twice, next cycle 4000_000C, imem_en low exactly in the stall cycle.
- redirect_valid with redirect_pc 4000_0100 at pc 4000_0010 -> that cycle valid 0 and inst 0000_0013, next cycle pc 4000_0100 valid 1.
- redirect_valid and stall together -> redirect taken, no HOLD, pc 4000_0100 next cycle.
- rst pulsed asynchronously mid-HOLD -> outputs immediately at reset values, then the BOOT sequence repeats from 4000_0000.
- With FETCH_SKID_EN, the imem model corrupts dout while imem_en = 0 -> HOLD still outputs the original instruction.
